// File: rtl/bmu_seq_unit.sv
// bmu_seq_unit
//   Multi-cycle bit-manipulation unit for CLMUL, CLMULH, CLMULR, CLZ, CPOP
//   and CTZ. Processes STEP operand bits per cycle over N = 32/STEP cycles
//   with a fixed, data-independent latency. Driven by the execute stage
//   through a start/busy/done handshake.
//
// Parameters
//   STEP     bits handled per iteration (1, 2, 4 or 8)
//
// Ports
//   clk_i    core clock, rising edge
//   rst_n_i  synchronous active-low reset
//   start_i  request, accepted when not busy and not killed
//   kill_i   pipeline flush, aborts a running operation, blocks acceptance
//   op_i     5-bit operation code (same encoding as the combinational BMU)
//   rs1_i    operand 1, sampled on acceptance
//   rs2_i    operand 2, sampled on acceptance (CLMUL family only)
//   busy_o   high while the iteration loop is running
//   done_o   one-cycle completion pulse
//   rd_o     result, valid with done_o and held until the next acceptance
module bmu_seq_unit #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [4:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rd_o
);

  localparam int unsigned N = 32 / STEP;

  localparam logic [4:0] OP_CLMUL  = 5'b00001;
  localparam logic [4:0] OP_CLMULH = 5'b00010;
  localparam logic [4:0] OP_CLMULR = 5'b00011;
  localparam logic [4:0] OP_CLZ    = 5'b00100;
  localparam logic [4:0] OP_CPOP   = 5'b00101;
  localparam logic [4:0] OP_CTZ    = 5'b00110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic        last_iter;

  logic [4:0]  op_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [63:0] acc_q, acc_nxt;
  logic        found_q, found_nxt;
  logic [4:0]  cnt_q;
  logic [31:0] rd_q, rd_nxt;

  logic [4:0]  bit_idx;
  logic        scan_bit;

  assign last_iter = (cnt_q == 5'(N - 1));
  assign rd_o      = rd_q;

  // Control FSM: next state, acceptance and status outputs.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !kill_i) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy_o = 1'b1;
        if (kill_i) begin
          state_d = S_IDLE;
        end else if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i && !kill_i) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One iteration of the datapath over STEP bit positions.
  // CTZ/CLZ count zeros met before the first 1 in scan order; an all-zero
  // operand therefore naturally yields 32 without a special case.
  always_comb begin
    acc_nxt   = acc_q;
    found_nxt = found_q;
    bit_idx   = '0;
    scan_bit  = 1'b0;
    for (int unsigned j = 0; j < STEP; j++) begin
      bit_idx = 5'((32'(cnt_q) * STEP) + j);
      case (op_q)
        OP_CLMUL, OP_CLMULH, OP_CLMULR: begin
          if (rs2_q[bit_idx]) begin
            acc_nxt = acc_nxt ^ ({32'b0, rs1_q} << bit_idx);
          end
        end
        OP_CPOP: begin
          acc_nxt = acc_nxt + 64'(rs1_q[bit_idx]);
        end
        OP_CTZ, OP_CLZ: begin
          scan_bit = (op_q == OP_CTZ) ? rs1_q[bit_idx] : rs1_q[5'd31 - bit_idx];
          if (!found_nxt) begin
            if (scan_bit) begin
              found_nxt = 1'b1;
            end else begin
              acc_nxt = acc_nxt + 64'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Result selection from the post-iteration accumulator, so rd can be
  // registered on the same edge that enters DONE.
  always_comb begin
    rd_nxt = '0;
    case (op_q)
      OP_CLMUL:                 rd_nxt = acc_nxt[31:0];
      OP_CLMULH:                rd_nxt = acc_nxt[63:32];
      OP_CLMULR:                rd_nxt = acc_nxt[62:31];
      OP_CPOP, OP_CTZ, OP_CLZ:  rd_nxt = acc_nxt[31:0];
      default:                  rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      acc_q   <= '0;
      found_q <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op_i;
        rs1_q   <= rs1_i;
        rs2_q   <= rs2_i;
        acc_q   <= '0;
        found_q <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == S_RUN && !kill_i) begin
        acc_q   <= acc_nxt;
        found_q <= found_nxt;
        cnt_q   <= cnt_q + 5'd1;
        if (last_iter) begin
          rd_q <= rd_nxt;
        end
      end
    end
  end

endmodule
